execute_unit: RTL and testbench
===============================

// Module: execute_unit
// PURPOSE
//  Execution stage downstream of the instruction decoder: consumes the 5-bit decoded control code (MC) plus the
//  4-bit operand nibble of the current ROM word, and updates an accumulator and flags.
//  Also emits the program-counter control pulses and drives a handshaked output port.
//  Multi-cycle sequencer: each instruction takes 3 cycles, plus any output-port stall cycles.
// PARAMETERS
//  DATA_W   8   accumulator / output port width (>=4)
//  ADDR_W   4   program-counter / jump-target width
// PORTS
//  CLK        in   1       single clock, rising edge
//  RST        in   1       asynchronous, active-high reset
//  MC         in   5       decoded control code from instruction decoder
//  OPERAND    in   4       low nibble of current ROM word (immediate / jump target)
//  PC_INC     out  1       one-cycle pulse: advance program counter
//  PC_LOAD    out  1       one-cycle pulse: load PC_TARGET into program counter
//  PC_TARGET  out  ADDR_W  jump address, zero-extended OPERAND, valid with PC_LOAD
//  ACC        out  DATA_W  accumulator
//  FLAG_Z     out  1       zero flag
//  FLAG_C     out  1       carry/borrow/shifted-out bit
//  OUT_DATA   out  DATA_W  output port data
//  OUT_VALID  out  1       output port valid; held until OUT_READY
//  OUT_READY  in   1       output consumer ready
//  HALTED     out  1       core halted
//  ILLEGAL    out  1       one-cycle pulse: unused MC code executed as NOP
// BEHAVIOUR
//  Reset (async, any state): state=FETCH; ACC, flags, OUT_DATA=0; all pulses/valid/HALTED=0.
//  MC codes: 0 NOP, 1 LDI, 2 ADDI, 3 SUBI, 4 ANDI, 5 ORI, 6 XORI, 7 SHL, 8 SHR, 9 JMP, 10 JZ, 11 JC,
//  12 OUT, 13 HALT. Codes 14..31 behave as NOP and pulse ILLEGAL in EXEC.
//  FSM: FETCH -> EXEC -> NEXT -> FETCH; EXEC -> OUT_WAIT for OUT; EXEC -> HALT for HALT.
//  FETCH: register MC/OPERAND into internal IR. Inputs are sampled only here; changes elsewhere are ignored.
//  EXEC:
//   - imm = zero-extended OPERAND. LDI: ACC=imm.
//   - ADDI/SUBI: DATA_W+1-bit result; C=carry out (ADD) or borrow (SUB); ACC wraps mod 2^DATA_W.
//   - AND/OR/XOR: C unchanged.
//   - SHL: C=ACC[MSB], shift in 0. SHR: C=ACC[0], shift in 0.
//   - Z recomputed from the new ACC on every ACC-writing op. NOP/jumps/OUT leave ACC/flags unchanged.
//   - JZ/JC sample the flags as they stand entering EXEC.
//  NEXT: exactly one of PC_INC or PC_LOAD is high for this cycle only.
//   - PC_LOAD for JMP, or JZ with Z=1, or JC with C=1; otherwise PC_INC.
//   - PC_TARGET is driven continuously from IR operand; wrap 15->0 is the counter's job.
//  OUT_WAIT: OUT_DATA=ACC, OUT_VALID=1 from the first OUT_WAIT cycle.
//   - Transfer completes on the cycle with OUT_VALID&OUT_READY; then OUT_VALID drops and state goes to NEXT.
//   - OUT_DATA is stable while valid. Minimum latency is 1 cycle even if OUT_READY is already high.
//  HALT: HALTED=1, no PC pulses, ACC frozen; only RST leaves HALT.
//  Latency: instruction at FETCH in cycle n has its ACC visible at n+2 and its PC pulse in cycle n+2 (NEXT).
//  Reset during OUT_WAIT drops OUT_VALID immediately (async), and the transfer is lost.
// STRUCTURE
//  Shared package exec_pkg: MC code localparams, FSM state encoding, DATA_W/ADDR_W defaults.
//  One sub-module: exec_alu (combinational: op, ACC, imm, flags -> new ACC, Z, C, writes_acc); the FSM
//  and registers live in execute_unit.
// TESTING
//  1. RST high 20 ns, then LDI 5 ; ADDI 3 -> ACC=8, Z=0, C=0; PC_INC pulses once per 3 cycles.
//  2. LDI 0 ; SUBI 1 -> ACC=0xFF, C=1, Z=0; then JC 9 -> PC_LOAD=1, PC_TARGET=9, PC_INC=0.
//  3. LDI 3 ; XORI 3 -> Z=1; JZ 4 -> PC_LOAD, target 4; LDI 1 ; JZ 4 -> PC_INC (not taken).
//  4. LDI 0xA ; SHL x4 -> ACC=0xA0 with C=0, then SHL -> ACC=0x40, C=1; SHR on 0x01 -> ACC=0, C=1, Z=1.
//  5. LDI 7 ; OUT with OUT_READY low 4 cycles -> OUT_VALID=1, OUT_DATA=7 held; no PC pulse until the
//     cycle after READY; single PC_INC follows.
//  6. MC=20 -> ILLEGAL pulse, ACC unchanged, PC_INC. HALT -> HALTED=1 with no pulses for 20 cycles.
//     RST asserted mid-EXEC -> outputs reset same cycle; restart from FETCH.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: control codes, FSM states, default widths
// and the instruction-register payload.
package exec_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned MC_W       = 5;
  localparam int unsigned OPND_W     = 4;

  localparam logic [MC_W-1:0] MC_NOP  = 5'd0;
  localparam logic [MC_W-1:0] MC_LDI  = 5'd1;
  localparam logic [MC_W-1:0] MC_ADDI = 5'd2;
  localparam logic [MC_W-1:0] MC_SUBI = 5'd3;
  localparam logic [MC_W-1:0] MC_ANDI = 5'd4;
  localparam logic [MC_W-1:0] MC_ORI  = 5'd5;
  localparam logic [MC_W-1:0] MC_XORI = 5'd6;
  localparam logic [MC_W-1:0] MC_SHL  = 5'd7;
  localparam logic [MC_W-1:0] MC_SHR  = 5'd8;
  localparam logic [MC_W-1:0] MC_JMP  = 5'd9;
  localparam logic [MC_W-1:0] MC_JZ   = 5'd10;
  localparam logic [MC_W-1:0] MC_JC   = 5'd11;
  localparam logic [MC_W-1:0] MC_OUT  = 5'd12;
  localparam logic [MC_W-1:0] MC_HALT = 5'd13;
  localparam logic [MC_W-1:0] MC_FIRST_ILLEGAL = 5'd14;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_NEXT,
    ST_OUT_WAIT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [MC_W-1:0]   mc;
    logic [OPND_W-1:0] operand;
  } ir_t;

  function automatic logic is_illegal(input logic [MC_W-1:0] mc);
    return mc >= MC_FIRST_ILLEGAL;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage: computes the new accumulator and flags
// for the instruction held in IR, and whether the op writes the accumulator at all.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [MC_W-1:0]   op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [DATA_W-1:0] acc_c,
  output logic              flag_z_c,
  output logic              flag_c_c,
  output logic              writes_acc_c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Top bit of the widened add/sub is carry-out or borrow respectively.
  assign sum  = {1'b0, acc} + {1'b0, imm};
  assign diff = {1'b0, acc} - {1'b0, imm};

  always_comb begin
    acc_c        = acc;
    flag_c_c     = flag_c;
    writes_acc_c = 1'b1;
    case (op)
      MC_LDI:  acc_c = imm;
      MC_ADDI: begin
        acc_c    = sum[DATA_W-1:0];
        flag_c_c = sum[DATA_W];
      end
      MC_SUBI: begin
        acc_c    = diff[DATA_W-1:0];
        flag_c_c = diff[DATA_W];
      end
      MC_ANDI: acc_c = acc & imm;
      MC_ORI:  acc_c = acc | imm;
      MC_XORI: acc_c = acc ^ imm;
      MC_SHL: begin
        acc_c    = {acc[DATA_W-2:0], 1'b0};
        flag_c_c = acc[DATA_W-1];
      end
      MC_SHR: begin
        acc_c    = {1'b0, acc[DATA_W-1:1]};
        flag_c_c = acc[0];
      end
      default: writes_acc_c = 1'b0;
    endcase
    flag_z_c = writes_acc_c ? (acc_c == '0) : flag_z;
  end

endmodule

// File: rtl/execute_unit.sv
// Three-cycle execute sequencer (FETCH/EXEC/NEXT) with output-port stall and halt states;
// owns the accumulator, flags, PC control pulses and the valid/ready output port.
module execute_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MC_W-1:0]   mc,
  input  logic [OPND_W-1:0] operand,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              illegal
);

  state_e state, state_d;
  ir_t    ir, ir_d;

  logic [DATA_W-1:0] acc_d, out_data_d, alu_acc_c;
  logic flag_z_d, flag_c_d, out_valid_d, halted_d, illegal_d;
  logic pc_inc_d, pc_load_d;
  logic alu_z_c, alu_c_c, alu_writes_c, jump_taken_c;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op           (ir.mc),
    .acc          (acc),
    .imm          (DATA_W'(ir.operand)),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .acc_c        (alu_acc_c),
    .flag_z_c     (alu_z_c),
    .flag_c_c     (alu_c_c),
    .writes_acc_c (alu_writes_c)
  );

  assign pc_target = ADDR_W'(ir.operand);

  // Conditional jumps look at the flags as they stand on entry to EXEC.
  assign jump_taken_c = (ir.mc == MC_JMP) ||
                        ((ir.mc == MC_JZ) && flag_z) ||
                        ((ir.mc == MC_JC) && flag_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      acc       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      pc_inc    <= 1'b0;
      pc_load   <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_d;
      ir        <= ir_d;
      acc       <= acc_d;
      flag_z    <= flag_z_d;
      flag_c    <= flag_c_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      pc_inc    <= pc_inc_d;
      pc_load   <= pc_load_d;
      halted    <= halted_d;
      illegal   <= illegal_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state;
    ir_d        = ir;
    acc_d       = acc;
    flag_z_d    = flag_z;
    flag_c_d    = flag_c;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    pc_inc_d    = 1'b0;
    pc_load_d   = 1'b0;
    halted_d    = halted;
    illegal_d   = 1'b0;

    case (state)
      ST_FETCH: begin
        ir_d      = '{mc: mc, operand: operand};
        illegal_d = is_illegal(mc);
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir.mc == MC_OUT) begin
          out_data_d  = acc;
          out_valid_d = 1'b1;
          state_d     = ST_OUT_WAIT;
        end else if (ir.mc == MC_HALT) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          if (alu_writes_c) begin
            acc_d    = alu_acc_c;
            flag_z_d = alu_z_c;
            flag_c_d = alu_c_c;
          end
          pc_load_d = jump_taken_c;
          pc_inc_d  = !jump_taken_c;
          state_d   = ST_NEXT;
        end
      end
      ST_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_inc_d    = 1'b1;
          state_d     = ST_NEXT;
        end
      end
      ST_NEXT: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed scenarios plus a random program
// compared against an instruction-level reference model.
module tb_execute_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] mc;
  logic [3:0] operand;
  logic       out_ready;
  logic       pc_inc, pc_load, flag_z, flag_c, out_valid, halted, illegal;
  logic [3:0] pc_target;
  logic [7:0] acc, out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference architectural state
  int m_acc;
  int m_z;
  int m_c;

  execute_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mc        (mc),
    .operand   (operand),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .acc       (acc),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_z   = 0;
    m_c   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".acc"}, 32'(acc), 0);
    check({tag, ".z"}, 32'(flag_z), 0);
    check({tag, ".c"}, 32'(flag_c), 0);
    check({tag, ".out_data"}, 32'(out_data), 0);
    check({tag, ".out_valid"}, 32'(out_valid), 0);
    check({tag, ".pulses"}, {29'd0, pc_inc, pc_load, illegal}, 0);
    check({tag, ".halted"}, 32'(halted), 0);
  endtask

  // Asynchronous reset pulse placed mid-cycle; leaves the DUT in FETCH before the next edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One instruction, entered while the DUT sits in FETCH before the capturing edge.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] opnd, input int ready_delay);
    int  imm, na, nz, nc, taken;
    bit  writes;
    imm = int'(opnd);
    na = m_acc; nz = m_z; nc = m_c; writes = 1'b1; taken = 0;
    case (op)
      5'd1: na = imm;
      5'd2: begin na = (m_acc + imm) % 256; nc = ((m_acc + imm) > 255) ? 1 : 0; end
      5'd3: begin na = (m_acc - imm + 256) % 256; nc = (m_acc < imm) ? 1 : 0; end
      5'd4: na = m_acc & imm;
      5'd5: na = m_acc | imm;
      5'd6: na = m_acc ^ imm;
      5'd7: begin na = (m_acc * 2) % 256; nc = (m_acc >= 128) ? 1 : 0; end
      5'd8: begin na = m_acc / 2; nc = m_acc % 2; end
      default: writes = 1'b0;
    endcase
    if (writes) nz = (na == 0) ? 1 : 0;
    if (op == 5'd9 || (op == 5'd10 && m_z == 1) || (op == 5'd11 && m_c == 1)) taken = 1;

    mc = op;
    operand = opnd;
    out_ready = (ready_delay == 0);
    @(posedge clk); #1;
    check("exec.illegal", 32'(illegal), (op >= 5'd14) ? 1 : 0);
    check("exec.pulses", {30'd0, pc_inc, pc_load}, 0);
    mc = 5'($urandom);
    operand = 4'($urandom);
    @(posedge clk); #1;

    if (op == 5'd13) begin
      for (int i = 0; i < 20; i++) begin
        check("halt.halted", 32'(halted), 1);
        check("halt.pulses", {30'd0, pc_inc, pc_load}, 0);
        check("halt.acc", 32'(acc), 32'(m_acc));
        mc = 5'($urandom);
        @(posedge clk); #1;
      end
      return;
    end

    if (op == 5'd12) begin
      for (int k = 0; k <= ready_delay; k++) begin
        check("out.valid", 32'(out_valid), 1);
        check("out.data", 32'(out_data), 32'(m_acc));
        check("out.pulses", {30'd0, pc_inc, pc_load}, 0);
        out_ready = (k == ready_delay);
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("out.valid_drop", 32'(out_valid), 0);
    end

    m_acc = na; m_z = nz; m_c = nc;
    check("next.acc", 32'(acc), 32'(m_acc));
    check("next.z", 32'(flag_z), 32'(m_z));
    check("next.c", 32'(flag_c), 32'(m_c));
    check("next.pc_inc", 32'(pc_inc), taken ? 0 : 1);
    check("next.pc_load", 32'(pc_load), 32'(taken));
    check("next.target", 32'(pc_target), 32'(opnd));
    check("next.halted", 32'(halted), 0);
    @(posedge clk); #1;
    check("fetch.pulses", {30'd0, pc_inc, pc_load}, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] rop;
    rst = 1'b1; mc = '0; operand = '0; out_ready = 1'b0;
    model_reset();
    #7;
    check_reset_outputs("reset");
    #13;
    rst = 1'b0;

    // Add with no carry
    run_instr(5'd1, 4'd5, 0);
    run_instr(5'd2, 4'd3, 0);
    // Borrow then taken JC
    run_instr(5'd1, 4'd0, 0);
    run_instr(5'd3, 4'd1, 0);
    run_instr(5'd11, 4'd9, 0);
    // JZ taken and not taken
    run_instr(5'd1, 4'd3, 0);
    run_instr(5'd6, 4'd3, 0);
    run_instr(5'd10, 4'd4, 0);
    run_instr(5'd1, 4'd1, 0);
    run_instr(5'd10, 4'd4, 0);
    // Shifts
    run_instr(5'd1, 4'hA, 0);
    for (int i = 0; i < 5; i++) run_instr(5'd7, 4'($urandom), 0);
    run_instr(5'd1, 4'd1, 0);
    run_instr(5'd8, 4'($urandom), 0);
    // Output port with stall, then with ready already high
    run_instr(5'd1, 4'd7, 0);
    run_instr(5'd12, 4'd0, 4);
    run_instr(5'd12, 4'd2, 0);
    // Illegal code
    run_instr(5'd20, 4'd6, 0);

    // Reset mid-EXEC discards the instruction
    run_instr(5'd1, 4'd9, 0);
    mc = 5'd2; operand = 4'd3;
    @(posedge clk); #1;
    apply_reset("rst_exec");
    run_instr(5'd2, 4'd3, 0);

    // Reset during OUT_WAIT drops valid immediately
    mc = 5'd12; operand = 4'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out.valid_before", 32'(out_valid), 1);
    apply_reset("rst_out");
    run_instr(5'd1, 4'd4, 0);

    // Random program
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(14, 31));
      else rop = 5'($urandom_range(0, 12));
      run_instr(rop, 4'($urandom), int'($urandom_range(0, 4)));
    end

    // Halt, then recover through reset
    run_instr(5'd13, 4'd0, 0);
    apply_reset("rst_halt");
    run_instr(5'd1, 4'd15, 0);
    run_instr(5'd9, 4'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
